// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage downstream of the ALU.
// Holds the NZCV flag register, evaluates the instruction condition field
// against the registered flags, and gates the decoder write requests.
module cond_logic #(
    parameter bit UNCOND_1111 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondExR,
    output logic [3:0] Flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_r_q;
    logic       cond_ex_r_d;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;

    assign n_flag = flags_q[3];
    assign z_flag = flags_q[2];
    assign c_flag = flags_q[1];
    assign v_flag = flags_q[0];

    // Condition check against the registered flags only, so an instruction never sees its own flag update
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = UNCOND_1111;
        endcase
    end

    // Next flag and registered-CondEx values; each flag group loads independently, stall freezes everything
    always_comb begin
        flag_write  = FlagW & {2{cond_ex}} & {2{~Stall}};
        flags_d     = flags_q;
        cond_ex_r_d = cond_ex_r_q;
        if (flag_write[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (flag_write[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
        if (!Stall) begin
            cond_ex_r_d = cond_ex;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            cond_ex_r_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cond_ex_r_q <= cond_ex_r_d;
        end
    end

    // Write strobes are combinational and held low throughout reset
    always_comb begin
        PCSrc    = PCS  & cond_ex & ~Stall & ~reset;
        RegWrite = RegW & cond_ex & ~NoWrite & ~Stall & ~reset;
        MemWrite = MemW & cond_ex & ~Stall & ~reset;
    end

    assign CondEx  = cond_ex;
    assign CondExR = cond_ex_r_q;
    assign Flags   = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed testbench for cond_logic. A second instance with UNCOND_1111=0
// shares all inputs so the never-execute encoding of Cond=1111 can be checked.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       CondExR;
    logic [3:0] Flags;
    logic       PCSrc0;
    logic       RegWrite0;
    logic       MemWrite0;
    logic       CondEx0;
    logic       CondExR0;
    logic [3:0] Flags0;

    int errors = 0;
    int checks = 0;

    cond_logic #(.UNCOND_1111(1'b1)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .CondExR(CondExR), .Flags(Flags)
    );

    cond_logic #(.UNCOND_1111(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Stall(Stall),
        .PCSrc(PCSrc0), .RegWrite(RegWrite0), .MemWrite(MemWrite0),
        .CondEx(CondEx0), .CondExR(CondExR0), .Flags(Flags0)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven well before the following edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Load both flag groups through an always-executed instruction
    task automatic load_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Cond = 4'b1110; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b want 0000", Flags); end
        checks++;
        if (CondExR !== 1'b0) begin errors++; $display("[TB] FAIL reset_condexr: got %b want 0", CondExR); end
        checks++;
        if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b want 000", {PCSrc, RegWrite, MemWrite});
        end
        reset = 1'b0;
        PCS = 1'b0; MemW = 1'b0; Cond = 4'b0000;
        #1;
        checks++;
        if ({CondEx, RegWrite} !== 2'b00) begin errors++; $display("[TB] FAIL reset_eq: got %b want 00", {CondEx, RegWrite}); end
        Cond = 4'b0001;
        #1;
        checks++;
        if ({CondEx, RegWrite} !== 2'b11) begin errors++; $display("[TB] FAIL reset_ne: got %b want 11", {CondEx, RegWrite}); end
        RegW = 1'b0;
    endtask

    task automatic test_alu_flags();
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0010;
        #1;
        checks++;
        if (Flags !== 4'b0000) begin errors++; $display("[TB] FAIL alu_same_cycle: got %b want 0000", Flags); end
        tick();
        FlagW = 2'b00; ALUFlags = 4'b0000;
        #1;
        checks++;
        if (Flags !== 4'b0010) begin errors++; $display("[TB] FAIL alu_flags: got %b want 0010", Flags); end
        checks++;
        if (CondExR !== 1'b1) begin errors++; $display("[TB] FAIL alu_condexr: got %b want 1", CondExR); end
        Cond = 4'b0010; PCS = 1'b1;
        #1;
        checks++;
        if (PCSrc !== 1'b1) begin errors++; $display("[TB] FAIL alu_cs_pcsrc: got %b want 1", PCSrc); end
        PCS = 1'b0; Cond = 4'b1000;
        #1;
        checks++;
        if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL alu_hi: got %b want 1", CondEx); end
    endtask

    task automatic test_split_groups();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b10;
        tick();
        #1;
        checks++;
        if (Flags !== 4'b1100) begin errors++; $display("[TB] FAIL split_nz: got %b want 1100", Flags); end
        FlagW = 2'b01; ALUFlags = 4'b0001;
        tick();
        FlagW = 2'b00;
        #1;
        checks++;
        if (Flags !== 4'b1101) begin errors++; $display("[TB] FAIL split_cv: got %b want 1101", Flags); end
        Cond = 4'b1101;
        #1;
        checks++;
        if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL split_le: got %b want 1", CondEx); end
        Cond = 4'b1100;
        #1;
        checks++;
        if (CondEx !== 1'b0) begin errors++; $display("[TB] FAIL split_gt: got %b want 0", CondEx); end
    endtask

    task automatic test_predicated();
        load_flags(4'b0100);
        Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b1010; RegW = 1'b1;
        #1;
        checks++;
        if ({CondEx, RegWrite} !== 2'b00) begin errors++; $display("[TB] FAIL pred_regwrite: got %b want 00", {CondEx, RegWrite}); end
        tick();
        FlagW = 2'b00; RegW = 1'b0;
        #1;
        checks++;
        if (Flags !== 4'b0100) begin errors++; $display("[TB] FAIL pred_flags: got %b want 0100", Flags); end
    endtask

    task automatic test_compare_stall();
        Cond = 4'b1110; RegW = 1'b1; NoWrite = 1'b1;
        #1;
        checks++;
        if (RegWrite !== 1'b0) begin errors++; $display("[TB] FAIL cmp_nowrite: got %b want 0", RegWrite); end
        NoWrite = 1'b0;
        #1;
        checks++;
        if (RegWrite !== 1'b1) begin errors++; $display("[TB] FAIL cmp_regwrite: got %b want 1", RegWrite); end
        RegW = 1'b0;
        tick();
        // CondExR is 1 here; a failing condition under stall must not load it
        Stall = 1'b1; Cond = 4'b0001;
        tick();
        #1;
        checks++;
        if (CondExR !== 1'b1) begin errors++; $display("[TB] FAIL stall_condexr: got %b want 1", CondExR); end
        Cond = 4'b1110; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1000;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin errors++; $display("[TB] FAIL stall_memwrite: got %b want 0", MemWrite); end
        tick();
        #1;
        checks++;
        if (Flags !== 4'b0100) begin errors++; $display("[TB] FAIL stall_flags: got %b want 0100", Flags); end
        Stall = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b1) begin errors++; $display("[TB] FAIL unstall_memwrite: got %b want 1", MemWrite); end
        tick();
        FlagW = 2'b00; MemW = 1'b0;
        #1;
        checks++;
        if (Flags !== 4'b1000) begin errors++; $display("[TB] FAIL unstall_flags: got %b want 1000", Flags); end
    endtask

    task automatic test_cond_table();
        logic [15:0] expv;
        load_flags(4'b1001);
        expv = 16'hD65A;
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i);
            #1;
            checks++;
            if (CondEx !== expv[i]) begin
                errors++; $display("[TB] FAIL table_1001 cond=%0d: got %b want %b", i, CondEx, expv[i]);
            end
        end
        load_flags(4'b0110);
        expv = 16'hE6A5;
        for (int i = 0; i < 16; i++) begin
            Cond = 4'(i);
            #1;
            checks++;
            if (CondEx !== expv[i]) begin
                errors++; $display("[TB] FAIL table_0110 cond=%0d: got %b want %b", i, CondEx, expv[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        load_flags(4'b1111);
        #1;
        checks++;
        if ({Flags, CondExR} !== 5'b11111) begin errors++; $display("[TB] FAIL pre_reset: got %b want 11111", {Flags, CondExR}); end
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if ({Flags, CondExR} !== 5'b00000) begin errors++; $display("[TB] FAIL async_clear: got %b want 00000", {Flags, CondExR}); end
        checks++;
        if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
            errors++; $display("[TB] FAIL async_strobes: got %b want 000", {PCSrc, RegWrite, MemWrite});
        end
        tick();
        checks++;
        if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin
            errors++; $display("[TB] FAIL async_strobes_hold: got %b want 000", {PCSrc, RegWrite, MemWrite});
        end
        reset = 1'b0;
        PCS = 1'b0; MemW = 1'b0; Cond = 4'b0000;
        #1;
        checks++;
        if ({CondEx, RegWrite} !== 2'b00) begin errors++; $display("[TB] FAIL post_reset_eq: got %b want 00", {CondEx, RegWrite}); end
        Cond = 4'b0001;
        #1;
        checks++;
        if ({CondEx, RegWrite} !== 2'b11) begin errors++; $display("[TB] FAIL post_reset_ne: got %b want 11", {CondEx, RegWrite}); end
        RegW = 1'b0; Cond = 4'b1111;
        #1;
        checks++;
        if (CondEx !== 1'b1) begin errors++; $display("[TB] FAIL uncond1_1111: got %b want 1", CondEx); end
        checks++;
        if (CondEx0 !== 1'b0) begin errors++; $display("[TB] FAIL uncond0_1111: got %b want 0", CondEx0); end
    endtask

    // Run every scenario in order, then report
    initial begin
        reset = 1'b1; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
        test_reset();
        test_alu_flags();
        test_split_groups();
        test_predicated();
        test_compare_stall();
        test_cond_table();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the ALU.
- Holds the architectural NZCV flag register, loaded from the ALU's ALUFlags output.
- Evaluates each instruction's 4-bit condition field against the registered flags.
- Gates the decoder's PCS/RegW/MemW requests into the final PCSrc/RegWrite/MemWrite strobes for the datapath.

Parameters:
- UNCOND_1111, 1: behaviour for Cond=4'b1111. 1 = always execute; 0 = never execute.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, bit 3 = N, bit 0 = V.
- FlagW  input  2  flag-write request from the decoder. [1] = N,Z group; [0] = C,V group.
- PCS  input  1  decoder request to write the PC.
- RegW  input  1  decoder request to write the register file.
- MemW  input  1  decoder request to write data memory.
- NoWrite  input  1  compare-class instruction; suppresses RegWrite.
- Stall  input  1  hold; freezes all state and kills all write strobes.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register-file write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  current condition-pass result (combinational).
- CondExR  output  1  CondEx registered one cycle, for multicycle control.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- Reset (async, while reset=1):
  - Flags=4'b0000, CondExR=0.
  - PCSrc, RegWrite and MemWrite forced 0 for as long as reset is high.
- CondEx is combinational from Cond and the registered Flags only. It never depends on same-cycle ALUFlags.
- Condition table (N,Z,C,V = Flags[3..0]):
  - 0000 EQ: Z.  0001 NE: !Z.
  - 0010 CS: C.  0011 CC: !C.
  - 0100 MI: N.  0101 PL: !N.
  - 0110 VS: V.  0111 VC: !V.
  - 1000 HI: C&!Z.  1001 LS: !C|Z.
  - 1010 GE: N==V.  1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).  1101 LE: Z|(N!=V).
  - 1110 AL: 1.  1111: UNCOND_1111.
- Flag write:
  - FlagWrite[1:0] = FlagW & {2{CondEx}} & {2{!Stall}}.
  - On a rising edge with FlagWrite[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - On a rising edge with FlagWrite[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two groups are independent. An unwritten group holds its value.
- Flag-update timing:
  - A flag-setting instruction in cycle t affects CondEx starting in cycle t+1.
  - An instruction cannot be predicated on its own flag update.
- Output gating (combinational, reset=0):
  - PCSrc = PCS & CondEx & !Stall.
  - RegWrite = RegW & CondEx & !NoWrite & !Stall.
  - MemWrite = MemW & CondEx & !Stall.
- CondExR:
  - Loads CondEx on each rising edge with Stall=0.
  - Holds its value while Stall=1.
- Simultaneous events:
  - FlagW active while CondEx=0: no flag change.
  - Stall=1 with FlagW=11: no flag change. After Stall drops, the same inputs are re-evaluated.
- Reset mid-operation: flags clear immediately (asynchronous). The first cycle after deassertion evaluates with Flags=0, so EQ fails and NE passes.
- Latency:
  - Strobes: 0 cycles (combinational).
  - Flags: 1 cycle.
  - CondExR: 1 cycle.
- No X propagation permitted: every Cond value, including 1111, yields a defined CondEx.

Test Plan:
- Reset, then Cond=0000 (EQ) with RegW=1 -> Flags=0000, CondEx=0, RegWrite=0. Switch to Cond=0001 (NE) -> CondEx=1, RegWrite=1.
- ALU case -2+3: ALUFlags=4'b0010, FlagW=11, Cond=1110 -> after 1 edge Flags=0010. Then Cond=0010 (CS) with PCS=1 -> PCSrc=1. Cond=1000 (HI) -> CondEx=1.
- Split groups: Flags=0000, ALUFlags=1111, FlagW=10 -> Flags=1100. Then FlagW=01 with ALUFlags=0001 -> Flags=1101. Cond=1101 (LE) -> CondEx=1. Cond=1100 (GT) -> CondEx=0.
- Predicated flag write: Flags=0100 (Z=1), Cond=0001 (NE), FlagW=11, ALUFlags=1010 -> Flags unchanged at 0100; RegWrite=0 even with RegW=1.
- Compare/stall: Cond=1110, RegW=1, NoWrite=1 -> RegWrite=0. Stall=1 with MemW=1, FlagW=11, ALUFlags=1000 -> MemWrite=0, Flags and CondExR unchanged. Drop Stall -> Flags=1000 on next edge.
- Async reset: with Flags=1111 and CondExR=1, pulse reset between edges -> Flags=0000 and CondExR=0 immediately. Write strobes read 0 throughout the pulse. Cond=1111 with UNCOND_1111=0 -> CondEx=0.
